// File: rtl/pe_operand_feeder_if.sv
`default_nettype none
// ============================================================================
// Module      : pe_operand_feeder_if
// Description : Operand-loading and PE operand-streaming signals between the
//               feeder (master) and its loader/PE side (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface pe_operand_feeder_if #(
    parameter int DEPTH = 8
) ();
    localparam int c_cnt_w = $clog2(DEPTH) + 1;

    logic               wr_valid;
    logic               wr_ready;
    logic [31:0]        wr_a;
    logic [31:0]        wr_b;
    logic               start;
    logic               busy;
    logic               done;
    logic               pe_valid;
    logic [31:0]        PE_a;
    logic [31:0]        PE_b;
    logic [c_cnt_w-1:0] count;

    // Feeder side: accepts loads and start, produces the PE operand stream
    modport master (
        input  wr_valid, wr_a, wr_b, start,
        output wr_ready, busy, done, pe_valid, PE_a, PE_b, count
    );

    // Loader / PE side
    modport slave (
        output wr_valid, wr_a, wr_b, start,
        input  wr_ready, busy, done, pe_valid, PE_a, PE_b, count
    );
endinterface
`default_nettype wire

// File: rtl/pe_operand_feeder.sv
`default_nettype none
// ============================================================================
// Module      : pe_operand_feeder
// Description : Buffers up to DEPTH FP32 operand pairs, streams them to one
//               systolic-array PE one pair per cycle on start, then drives
//               FLUSH_CYCLES zero-operand cycles and pulses done.
// Revision    : 1.0 - initial release
// ============================================================================
module pe_operand_feeder #(
    parameter int DEPTH        = 8,
    parameter int FLUSH_CYCLES = 4
) (
    input  wire logic            clk,
    input  wire logic            rst,
    pe_operand_feeder_if.master  bus
);
    localparam int c_ptr_w   = $clog2(DEPTH);
    localparam int c_cnt_w   = c_ptr_w + 1;
    localparam int c_flush_w = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    localparam logic [c_ptr_w-1:0]   c_ptr_one    = 1;
    localparam logic [c_cnt_w-1:0]   c_cnt_one    = 1;
    localparam logic [c_cnt_w-1:0]   c_cnt_full   = DEPTH;
    localparam logic [c_flush_w-1:0] c_flush_one  = 1;
    localparam logic [c_flush_w-1:0] c_flush_last = FLUSH_CYCLES - 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2
    } state_t;

    state_t               r_state;
    logic [31:0]          r_mem_a [DEPTH];
    logic [31:0]          r_mem_b [DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_cnt_w-1:0]   r_count;
    logic [c_cnt_w-1:0]   r_sent;
    logic [c_flush_w-1:0] r_flush;
    logic [31:0]          r_pe_a;
    logic [31:0]          r_pe_b;
    logic                 r_pe_valid;
    logic                 r_busy;
    logic                 r_done;

    logic                 w_wr_ready;
    logic                 w_wr_fire;

    assign w_wr_ready = (r_state == ST_IDLE) && (r_count < c_cnt_full);
    assign w_wr_fire  = bus.wr_valid && w_wr_ready;

    assign bus.wr_ready = w_wr_ready;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.pe_valid = r_pe_valid;
    assign bus.PE_a     = r_pe_a;
    assign bus.PE_b     = r_pe_b;
    assign bus.count    = r_count;

    // Operand buffer storage; contents are never cleared, only the pointers are
    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            r_mem_a[r_wr_ptr] <= bus.wr_a;
            r_mem_b[r_wr_ptr] <= bus.wr_b;
        end
    end

    // Load / stream / flush sequencer with registered PE outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_sent     <= '0;
            r_flush    <= '0;
            r_pe_a     <= '0;
            r_pe_b     <= '0;
            r_pe_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_wr_fire) begin
                        r_wr_ptr <= r_wr_ptr + c_ptr_one;
                        r_count  <= r_count + c_cnt_one;
                    end
                    // A write landing on the start edge becomes the last pair;
                    // pair 0 is already in the buffer so it can go out now.
                    if (bus.start && (r_count != '0)) begin
                        r_state    <= ST_STREAM;
                        r_busy     <= 1'b1;
                        r_pe_a     <= r_mem_a[r_rd_ptr];
                        r_pe_b     <= r_mem_b[r_rd_ptr];
                        r_pe_valid <= 1'b1;
                        r_rd_ptr   <= r_rd_ptr + c_ptr_one;
                        r_sent     <= c_cnt_one;
                    end
                end
                ST_STREAM: begin
                    if (r_sent == r_count) begin
                        r_pe_a     <= '0;
                        r_pe_b     <= '0;
                        r_pe_valid <= 1'b0;
                        // A single flush cycle completes on this very edge
                        if (FLUSH_CYCLES == 1) begin
                            r_state  <= ST_IDLE;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                            r_count  <= '0;
                            r_rd_ptr <= '0;
                            r_wr_ptr <= '0;
                        end else begin
                            r_state <= ST_FLUSH;
                            r_flush <= c_flush_one;
                        end
                    end else begin
                        r_pe_a   <= r_mem_a[r_rd_ptr];
                        r_pe_b   <= r_mem_b[r_rd_ptr];
                        r_rd_ptr <= r_rd_ptr + c_ptr_one;
                        r_sent   <= r_sent + c_cnt_one;
                    end
                end
                ST_FLUSH: begin
                    if (r_flush == c_flush_last) begin
                        r_state  <= ST_IDLE;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_count  <= '0;
                        r_rd_ptr <= '0;
                        r_wr_ptr <= '0;
                    end else begin
                        r_flush <= r_flush + c_flush_one;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_pe_operand_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_pe_operand_feeder
// Description : Self-checking bench for pe_operand_feeder: queue-based model
//               compared every cycle, plus directed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_operand_feeder;
    localparam int DEPTH        = 8;
    localparam int FLUSH_CYCLES = 4;

    logic clk;
    logic rst;

    pe_operand_feeder_if #(.DEPTH(DEPTH)) bus ();

    pe_operand_feeder #(
        .DEPTH        (DEPTH),
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%08h expected=0x%08h @%0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: a queue of loaded pairs; a start turns the queue into a
    // per-cycle schedule of expected outputs (N pairs, then FLUSH_CYCLES
    // zero cycles, the last of which carries done).
    // ------------------------------------------------------------------
    typedef struct packed {
        logic        v;
        logic [31:0] a;
        logic [31:0] b;
        logic        busy;
        logic        done;
    } rec_t;

    logic [63:0] mq[$];
    rec_t        sched[$];
    rec_t        m_r;
    int          m_n;
    logic        e_v, e_busy, e_done;
    logic [31:0] e_a, e_b;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            sched.delete();
            e_v = 1'b0; e_a = '0; e_b = '0; e_busy = 1'b0; e_done = 1'b0;
        end else if (sched.size() > 0) begin
            m_r = sched.pop_front();
            e_v = m_r.v; e_a = m_r.a; e_b = m_r.b; e_busy = m_r.busy; e_done = m_r.done;
            if (m_r.done) mq.delete();
        end else begin
            e_done = 1'b0;
            m_n = mq.size();
            if (bus.wr_valid && mq.size() < DEPTH) mq.push_back({bus.wr_a, bus.wr_b});
            if (bus.start && m_n > 0) begin
                for (int k = 0; k < mq.size(); k++) begin
                    m_r.v = 1'b1; m_r.a = mq[k][63:32]; m_r.b = mq[k][31:0];
                    m_r.busy = 1'b1; m_r.done = 1'b0;
                    sched.push_back(m_r);
                end
                for (int k = 0; k < FLUSH_CYCLES; k++) begin
                    m_r.v = 1'b0; m_r.a = '0; m_r.b = '0;
                    m_r.busy = (k != FLUSH_CYCLES - 1);
                    m_r.done = (k == FLUSH_CYCLES - 1);
                    sched.push_back(m_r);
                end
                m_r = sched.pop_front();
                e_v = m_r.v; e_a = m_r.a; e_b = m_r.b; e_busy = m_r.busy; e_done = m_r.done;
            end
        end
    end

    // Per-cycle comparison of every DUT output against the model
    always @(negedge clk) begin
        check("pe_valid", {31'b0, bus.pe_valid}, {31'b0, e_v});
        check("PE_a", bus.PE_a, e_a);
        check("PE_b", bus.PE_b, e_b);
        check("busy", {31'b0, bus.busy}, {31'b0, e_busy});
        check("done", {31'b0, bus.done}, {31'b0, e_done});
        check("count", 32'(bus.count), 32'(mq.size()));
        check("wr_ready", {31'b0, bus.wr_ready},
              {31'b0, (sched.size() == 0) && (mq.size() < DEPTH)});
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    task automatic wr(input logic [31:0] a, input logic [31:0] b);
        bus.wr_valid = 1'b1;
        bus.wr_a     = a;
        bus.wr_b     = b;
        @(negedge clk);
        bus.wr_valid = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic run_cycles(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            if (bus.done) pulses++;
            @(negedge clk);
        end
    endtask

    logic [31:0] got_a [8];
    logic [31:0] got_b [8];
    logic        got_v [8];
    int          pulses;

    initial begin
        rst = 1'b1;
        bus.wr_valid = 1'b0; bus.wr_a = '0; bus.wr_b = '0; bus.start = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_pe_valid", {31'b0, bus.pe_valid}, 32'd0);
        check("rst_busy", {31'b0, bus.busy}, 32'd0);
        check("rst_PE_a", bus.PE_a, 32'd0);
        check("rst_wr_ready", {31'b0, bus.wr_ready}, 32'd1);
        check("rst_count", 32'(bus.count), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic 4-pair stream
        wr(32'h4000_0000, 32'h4100_0000);
        wr(32'h4080_0000, 32'h4100_0000);
        wr(32'h4100_0000, 32'h4100_0000);
        wr(32'h4180_0000, 32'h4100_0000);
        pulse_start();
        for (int k = 0; k < 4; k++) begin
            got_a[k] = bus.PE_a; got_b[k] = bus.PE_b; got_v[k] = bus.pe_valid;
            @(negedge clk);
        end
        check("basic_a0", got_a[0], 32'h4000_0000);
        check("basic_a1", got_a[1], 32'h4080_0000);
        check("basic_a2", got_a[2], 32'h4100_0000);
        check("basic_a3", got_a[3], 32'h4180_0000);
        check("basic_b3", got_b[3], 32'h4100_0000);
        check("basic_v0", {31'b0, got_v[0]}, 32'd1);
        check("basic_flush_valid", {31'b0, bus.pe_valid}, 32'd0);
        run_cycles(16, pulses);
        check("basic_done_pulses", 32'(pulses), 32'd1);

        // Full buffer: 9 writes with wr_valid held, the 9th is dropped
        bus.wr_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            bus.wr_a = 32'h3F80_0000 + 32'(i);
            bus.wr_b = 32'h4000_0000 + 32'(i);
            @(negedge clk);
            if (i == 7) check("full_wr_ready", {31'b0, bus.wr_ready}, 32'd0);
        end
        bus.wr_valid = 1'b0;
        check("full_count", 32'(bus.count), 32'd8);
        pulse_start();
        for (int k = 0; k < 8; k++) begin
            got_a[k] = bus.PE_a; got_v[k] = bus.pe_valid;
            @(negedge clk);
        end
        for (int k = 0; k < 8; k++) begin
            check("full_a", got_a[k], 32'h3F80_0000 + 32'(k));
            check("full_v", {31'b0, got_v[k]}, 32'd1);
        end
        run_cycles(12, pulses);
        check("full_done_pulses", 32'(pulses), 32'd1);

        // Start with an empty buffer is ignored
        pulse_start();
        check("empty_busy", {31'b0, bus.busy}, 32'd0);
        check("empty_valid", {31'b0, bus.pe_valid}, 32'd0);
        run_cycles(6, pulses);
        check("empty_done_pulses", 32'(pulses), 32'd0);

        // Start and write on the same edge: 3-pair stream
        wr(32'h3F80_0000, 32'h4000_0000);
        wr(32'h4040_0000, 32'h4000_0000);
        bus.start = 1'b1; bus.wr_valid = 1'b1;
        bus.wr_a = 32'h4180_0000; bus.wr_b = 32'h4000_0000;
        @(negedge clk);
        bus.start = 1'b0; bus.wr_valid = 1'b0;
        check("same_count", 32'(bus.count), 32'd3);
        for (int k = 0; k < 3; k++) begin
            got_a[k] = bus.PE_a; got_v[k] = bus.pe_valid;
            @(negedge clk);
        end
        check("same_a0", got_a[0], 32'h3F80_0000);
        check("same_a1", got_a[1], 32'h4040_0000);
        check("same_a2", got_a[2], 32'h4180_0000);
        check("same_v2", {31'b0, got_v[2]}, 32'd1);
        check("same_end_valid", {31'b0, bus.pe_valid}, 32'd0);
        run_cycles(10, pulses);
        check("same_done_pulses", 32'(pulses), 32'd1);

        // Reset during the second stream cycle
        wr(32'h4000_0000, 32'h4000_0000);
        wr(32'h4040_0000, 32'h4040_0000);
        wr(32'h4080_0000, 32'h4080_0000);
        pulse_start();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_valid", {31'b0, bus.pe_valid}, 32'd0);
        check("midrst_busy", {31'b0, bus.busy}, 32'd0);
        check("midrst_count", 32'(bus.count), 32'd0);
        check("midrst_PE_a", bus.PE_a, 32'd0);
        run_cycles(10, pulses);
        check("midrst_done_pulses", 32'(pulses), 32'd0);

        // Recovery: one pair loads and completes normally
        wr(32'h4120_0000, 32'h4130_0000);
        pulse_start();
        check("recov_a", bus.PE_a, 32'h4120_0000);
        check("recov_b", bus.PE_b, 32'h4130_0000);
        run_cycles(10, pulses);
        check("recov_done_pulses", 32'(pulses), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
